// File: rtl/alu_pkg.sv
// Shared ALU opcodes and sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SHL   = 3'b101;
  localparam logic [2:0] ALU_PASSA = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/vector_alu_sequencer.sv
// Time-multiplexes one external scalar ALU across the lanes of a vector op.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an op; in_ready high; operands captured on accept
// RUN     | one lane per cycle through the ALU; result and flags build up
// DONE    | result vector and flags held until the output handshake
module vector_alu_sequencer
  import alu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ELEM_W = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [LANES*ELEM_W-1:0]   in_a,
  input  logic [LANES*ELEM_W-1:0]   in_b,
  input  logic [LANES-1:0]          in_mask,
  output logic [ELEM_W-1:0]         alu_a,
  output logic [ELEM_W-1:0]         alu_b,
  output logic [2:0]                alu_sel,
  input  logic [ELEM_W-1:0]         alu_out,
  input  logic                      alu_n,
  input  logic                      alu_z,
  input  logic                      alu_v,
  input  logic                      alu_c,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ELEM_W-1:0]   out_result,
  output logic                      out_n,
  output logic                      out_z,
  output logic                      out_v,
  output logic                      out_c
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  seq_state_e state_q, state_d;

  logic [LW-1:0]           lane_q;
  logic [2:0]              op_q;
  logic [LANES*ELEM_W-1:0] a_q, b_q, res_q;
  logic [LANES-1:0]        mask_q;
  logic                    n_acc, z_acc, v_acc, c_acc;
  logic                    valid_q;

  logic [ELEM_W-1:0]       a_lane, b_lane;
  logic                    lane_en;
  logic                    last_lane;

  // Current-lane operand slices come only from registered state.
  assign a_lane    = a_q[lane_q*ELEM_W +: ELEM_W];
  assign b_lane    = b_q[lane_q*ELEM_W +: ELEM_W];
  assign lane_en   = mask_q[lane_q];
  assign last_lane = (lane_q == LAST_LANE);

  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_n      = n_acc;
  assign out_z      = z_acc;
  assign out_v      = v_acc;
  assign out_c      = c_acc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode plus in_ready and the ALU drive.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    alu_sel  = ALU_PASSA;
    alu_a    = '0;
    alu_b    = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        alu_sel = op_q;
        alu_a   = a_lane;
        alu_b   = b_lane;
        if (last_lane) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, per-lane result/flag accumulation and the output valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= '0;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      res_q   <= '0;
      n_acc   <= 1'b0;
      z_acc   <= 1'b0;
      v_acc   <= 1'b0;
      c_acc   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q   <= in_op;
            a_q    <= in_a;
            b_q    <= in_b;
            mask_q <= in_mask;
            lane_q <= '0;
            n_acc  <= 1'b0;
            z_acc  <= 1'b1;
            v_acc  <= 1'b0;
            c_acc  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Disabled lanes pass A through but still cost a cycle, keeping latency fixed.
          res_q[lane_q*ELEM_W +: ELEM_W] <= lane_en ? alu_out : a_lane;
          if (lane_en) begin
            n_acc <= n_acc | alu_n;
            v_acc <= v_acc | alu_v;
            c_acc <= c_acc | alu_c;
            z_acc <= z_acc & alu_z;
          end
          if (last_lane) begin
            lane_q  <= '0;
            valid_q <= 1'b1;
          end else begin
            lane_q  <= lane_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) valid_q <= 1'b0;
        end
        default: valid_q <= 1'b0;
      endcase
    end
  end

endmodule
